// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result handshake bundle for the pipelined adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, s, c, ovf
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, s, c, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : STAGES-deep chunked adder/subtractor with valid/ready flow.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_adder_if.slave    bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage inputs: stage 0 is fed from the ports, stage k from stage k-1.
    logic [WIDTH-1:0] px [STAGES];
    logic [WIDTH-1:0] py [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic             pc [STAGES];
    logic             pv [STAGES];

    logic [WIDTH-1:0] x_d [STAGES];
    logic [WIDTH-1:0] x_q [STAGES];
    logic [WIDTH-1:0] y_d [STAGES];
    logic [WIDTH-1:0] y_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_d [STAGES];
    logic             c_q [STAGES];
    logic             v_d [STAGES];
    logic             v_q [STAGES];
    logic             ovf_d;
    logic             ovf_q;

    logic             adv;
    logic [WIDTH-1:0] y_eff;
    logic             carry0;

    assign adv          = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready = adv;
    assign y_eff        = bus.sub ? ~bus.y : bus.y;
    assign carry0       = bus.sub | bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0] chunk;

        if (k == 0) begin : g_head
            assign px[k] = bus.x;
            assign py[k] = y_eff;
            assign ps[k] = '0;
            assign pc[k] = carry0;
            assign pv[k] = bus.in_valid;
        end else begin : g_body
            assign px[k] = x_q[k-1];
            assign py[k] = y_q[k-1];
            assign ps[k] = s_q[k-1];
            assign pc[k] = c_q[k-1];
            assign pv[k] = v_q[k-1];
        end

        always_comb begin
            chunk  = {1'b0, px[k][k*CW +: CW]} + {1'b0, py[k][k*CW +: CW]}
                   + {{CW{1'b0}}, pc[k]};
            x_d[k] = px[k];
            y_d[k] = py[k];
            v_d[k] = pv[k];
            c_d[k] = chunk[CW];
            s_d[k] = ps[k];
            s_d[k][k*CW +: CW] = chunk[CW-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end else if (adv) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
        end
    end

    // Overflow uses the operand MSBs carried into the last stage.
    always_comb begin
        ovf_d = (px[LAST][WIDTH-1] == py[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != px[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.s         = s_q[LAST];
    assign bus.c         = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = v_q[LAST];
endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Self-checking bench for pipelined_adder (WIDTH=8, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int PERIOD = 10;

    typedef struct packed {
        logic       ovf;
        logic       c;
        logic [7:0] s;
    } res_t;

    logic clk;
    logic rst;
    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks    = 0;
    int   errors    = 0;
    int   n_in      = 0;
    int   n_out     = 0;
    int   n_flushed = 0;
    res_t exp_q[$];

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    // Reference: signed/unsigned integer arithmetic, independent of chunking.
    function automatic res_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic sb);
        int   ua, ub, ur, sa, sv, sr;
        res_t r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sv = int'($signed(b));
        if (sb) begin
            ur  = ua - ub;
            sr  = sa - sv;
            r.c = (ua >= ub);
        end else begin
            ur  = ua + ub + int'(ci);
            sr  = sa + sv + int'(ci);
            r.c = (ur > 255);
        end
        r.s   = ur[7:0];
        r.ovf = (sr > 127) || (sr < -128);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: on each negedge, handshakes seen here complete at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            n_flushed += exp_q.size();
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out got s=%0h c=%0b ovf=%0b expected no beat",
                             bus.s, bus.c, bus.ovf);
                end else begin
                    if ({bus.ovf, bus.c, bus.s} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL result got ovf/c/s=%0b/%0b/%0h expected %0b/%0b/%0h",
                                 bus.ovf, bus.c, bus.s, exp_q[0].ovf, exp_q[0].c, exp_q[0].s);
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.x, bus.y, bus.cin, bus.sub));
                n_in++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb);
        bit acc;
        int n;
        bus.x = a;
        bus.y = b;
        bus.cin = ci;
        bus.sub = sb;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 for %0d cycles expected accept", n);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        time  t0;
        int   out0;
        bit   acc;
        res_t head;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_s",         {24'd0, bus.s},         32'd0);
        chk("rst_c",         {31'd0, bus.c},         32'd0);
        chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

        // Hand-computed pins of the reference model (ovf, c, s).
        chk("model_ff_01",    {22'd0, ref_model(8'hFF, 8'h01, 1'b0, 1'b0)}, {22'd0, 1'b0, 1'b1, 8'h00});
        chk("model_7f_01",    {22'd0, ref_model(8'h7F, 8'h01, 1'b0, 1'b0)}, {22'd0, 1'b1, 1'b0, 8'h80});
        chk("model_80_m01",   {22'd0, ref_model(8'h80, 8'h01, 1'b0, 1'b1)}, {22'd0, 1'b1, 1'b1, 8'h7F});
        chk("model_05_m07",   {22'd0, ref_model(8'h05, 8'h07, 1'b1, 1'b1)}, {22'd0, 1'b0, 1'b0, 8'hFE});
        chk("model_0f_01_ci", {22'd0, ref_model(8'h0F, 8'h01, 1'b1, 1'b0)}, {22'd0, 1'b0, 1'b0, 8'h11});

        // Latency: result valid after exactly two edges.
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("lat_edge1_valid", {31'd0, bus.out_valid}, 32'd0);
        idle(1);
        chk("lat_edge2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_s",           {24'd0, bus.s},         32'h00);
        chk("lat_c",           {31'd0, bus.c},         32'd1);
        chk("lat_ovf",         {31'd0, bus.ovf},       32'd0);

        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1);
        send(8'h05, 8'h07, 1'b1, 1'b1);
        send(8'h0F, 8'h01, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b0, 1'b1);
        send(8'h00, 8'h80, 1'b0, 1'b1);
        idle(4);

        // Back-to-back stream: one accept per cycle, every beat comes out.
        out0 = n_out;
        t0 = $time;
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("stream_cycles", 32'(($time - t0) / PERIOD), 32'd16);
        idle(4);
        chk("stream_count", 32'(n_out - out0), 32'd16);

        // Backpressure: two beats fill the pipe, third must wait.
        bus.out_ready = 1'b0;
        send(8'h7F, 8'h7F, 1'b0, 1'b0);
        send(8'h10, 8'h20, 1'b0, 1'b1);
        head = ref_model(8'h7F, 8'h7F, 1'b0, 1'b0);
        bus.x = 8'hAA;
        bus.y = 8'h55;
        bus.cin = 1'b1;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold",      {22'd0, bus.ovf, bus.c, bus.s}, {22'd0, head});
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        chk("bp_release_accept", {31'd0, acc}, 32'd1);
        bus.in_valid = 1'b0;
        idle(4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight: they are discarded.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        out0 = n_out;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_s",         {24'd0, bus.s},         32'd0);
        chk("flush_c",         {31'd0, bus.c},         32'd0);
        chk("flush_ovf",       {31'd0, bus.ovf},       32'd0);
        chk("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("flush_no_out", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("flush_count", 32'(n_out - out0), 32'd0);
        chk("flushed_beats", 32'(n_flushed), 32'd2);

        send(8'hC0, 8'h40, 1'b0, 1'b0);
        idle(4);
        chk("balance", 32'(n_out + n_flushed), 32'(n_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
